adder_tree_frame_collector: RTL and testbench

- Upstream/downstream wrapper stage for the float-to-fixed adder tree.
- Accepts a serial stream of IEEE-754 single-precision elements with a valid/ready handshake and packs them into a NUM_ELEMENTS-wide parallel vector that drives the tree's inputs.
- Holds that vector stable for the tree's pipeline latency, captures the tree's float sum, and presents it downstream with a valid/ready handshake.

---
 rtl/adder_tree_frame_collector.sv | 201 ++++++++++++++++++++
 tb/tb_adder_tree_frame_collector.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_tree_frame_collector.sv
// adder_tree_frame_collector
//
// Wrapper stage around the float-to-fixed adder tree. It collects a serial stream of
// IEEE-754 single-precision elements into a NUM_ELEMENTS-wide parallel vector and holds
// that vector stable while the tree computes. Once the tree output is valid, it registers
// the float sum and presents it downstream with a valid/ready handshake. Only one frame is
// in flight at a time.
//
// Optional feature: define COLLECTOR_NAN_FLAG_EN to build a sticky NaN/Inf detector. The
// detector result is reported on sum_invalid. Without the macro, sum_invalid is tied to 0.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready     element handshake; in_data is the element, in_last ends the frame
//   vec_out               parallel vector driven into the adder tree
//   tree_sum              float sum returned by the adder tree
//   sum_valid/sum_ready   result handshake; sum_data is the registered frame sum
//   sum_invalid           the frame contained a NaN/Inf element (feature build only)

module adder_tree_frame_collector #(
    parameter int unsigned NUM_ELEMENTS     = 50,
    parameter int unsigned DATA_WIDTH_float = 32,
    parameter int unsigned TREE_LATENCY     = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_WIDTH_float-1:0] in_data,
    input  logic                        in_last,
    output logic [DATA_WIDTH_float-1:0] vec_out [NUM_ELEMENTS],
    input  logic [DATA_WIDTH_float-1:0] tree_sum,
    output logic                        sum_valid,
    input  logic                        sum_ready,
    output logic [DATA_WIDTH_float-1:0] sum_data,
    output logic                        sum_invalid
);

    localparam int unsigned IDX_W = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1;
    localparam int unsigned CNT_W = (TREE_LATENCY > 1) ? $clog2(TREE_LATENCY + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMENTS - 1);
    localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(TREE_LATENCY);

    typedef enum logic [1:0] {
        StFill,
        StHold,
        StOut
    } state_e;

    state_e state_q, state_d;

    logic [DATA_WIDTH_float-1:0] vec_q [NUM_ELEMENTS];
    logic [DATA_WIDTH_float-1:0] vec_d [NUM_ELEMENTS];
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH_float-1:0] sum_data_q, sum_data_d;
    logic                        sum_valid_q, sum_valid_d;

    logic take;
    logic close_frame;
    logic hold_done;
    logic sum_hs;

    assign take        = in_valid && in_ready;
    assign close_frame = take && (in_last || (idx_q == LAST_IDX));
    // The vector became stable at the closing edge. The tree output is valid after
    // TREE_LATENCY further edges, so the capture happens one edge later. This puts
    // sum_valid TREE_LATENCY+1 cycles after the closing transfer.
    assign hold_done   = (state_q == StHold) && (cnt_q == HOLD_END);
    assign sum_hs      = sum_valid_q && sum_ready;

    // ---------------------------------------------------------------- FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFill;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFill: if (close_frame) state_d = StHold;
            StHold: if (hold_done)   state_d = StOut;
            StOut:  if (sum_hs)      state_d = StFill;
            default:                 state_d = StFill;
        endcase
    end

    // ---------------------------------------------------------------- FSM: outputs
    always_comb begin
        in_ready = (state_q == StFill);
    end

    // ---------------------------------------------------------------- datapath next state
    always_comb begin
        vec_d       = vec_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        sum_data_d  = sum_data_q;
        sum_valid_d = sum_valid_q;

        if (take) begin
            vec_d[idx_q] = in_data;
            if (close_frame) begin
                cnt_d = '0;
                // An early in_last pads the unused tail with +0.0 so the tree sees no
                // stale data.
                for (int i = 0; i < int'(NUM_ELEMENTS); i++) begin
                    if (i > int'(idx_q)) begin
                        vec_d[i] = '0;
                    end
                end
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end

        if (state_q == StHold) begin
            if (hold_done) begin
                sum_data_d  = tree_sum;
                sum_valid_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        if (sum_hs) begin
            sum_valid_d = 1'b0;
            idx_d       = '0;
            for (int i = 0; i < int'(NUM_ELEMENTS); i++) begin
                vec_d[i] = '0;
            end
        end
    end

    // ---------------------------------------------------------------- datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_ELEMENTS); i++) begin
                vec_q[i] <= '0;
            end
            idx_q       <= '0;
            cnt_q       <= '0;
            sum_data_q  <= '0;
            sum_valid_q <= 1'b0;
        end else begin
            vec_q       <= vec_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            sum_data_q  <= sum_data_d;
            sum_valid_q <= sum_valid_d;
        end
    end

    assign vec_out   = vec_q;
    assign sum_data  = sum_data_q;
    assign sum_valid = sum_valid_q;

`ifdef COLLECTOR_NAN_FLAG_EN
    // Sticky NaN/Inf detector. The float-to-fixed conversion saturates these values
    // silently, so the consumer is warned alongside the sum.
    logic nan_flag_q, nan_flag_d;
    logic sum_invalid_q, sum_invalid_d;
    logic elem_special;

    assign elem_special = (in_data[DATA_WIDTH_float-2 -: 8] == 8'hFF);

    always_comb begin
        nan_flag_d    = nan_flag_q;
        sum_invalid_d = sum_invalid_q;
        if (take && elem_special) begin
            nan_flag_d = 1'b1;
        end
        if (hold_done) begin
            sum_invalid_d = nan_flag_q;
        end
        if (sum_hs) begin
            nan_flag_d    = 1'b0;
            sum_invalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nan_flag_q    <= 1'b0;
            sum_invalid_q <= 1'b0;
        end else begin
            nan_flag_q    <= nan_flag_d;
            sum_invalid_q <= sum_invalid_d;
        end
    end

    assign sum_invalid = sum_invalid_q;
`else
    assign sum_invalid = 1'b0;
`endif

endmodule

// File: tb/tb_adder_tree_frame_collector.sv
// Directed bench for adder_tree_frame_collector. A small adder-tree stand-in drives
// tree_sum. It returns the expected sum only after vec_out has been stable for
// TREE_LATENCY edges, and returns a poison value before that.

module tb_adder_tree_frame_collector;

    localparam int N = 50;
    localparam int L = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic [31:0] vec_out [N];
    logic [31:0] tree_sum;
    logic        sum_valid;
    logic        sum_ready = 1'b0;
    logic [31:0] sum_data;
    logic        sum_invalid;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    int stable = 0;
    logic [31:0] exp_tree = '0;
    logic [31:0] snap [N];

    adder_tree_frame_collector #(
        .NUM_ELEMENTS    (N),
        .DATA_WIDTH_float(32),
        .TREE_LATENCY    (L)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .vec_out    (vec_out),
        .tree_sum   (tree_sum),
        .sum_valid  (sum_valid),
        .sum_ready  (sum_ready),
        .sum_data   (sum_data),
        .sum_invalid(sum_invalid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Tree stand-in: count edges over which vec_out has not changed.
    always @(negedge clk) begin
        bit chg;
        chg = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (vec_out[i] !== snap[i]) chg = 1'b1;
            snap[i] = vec_out[i];
        end
        stable = chg ? 0 : stable + 1;
    end

    assign tree_sum = (stable >= L) ? exp_tree : 32'hDEADBEEF;

    // Stimulus: push n elements (the last one carries vlast and in_last).
    task automatic push_frame(input logic [31:0] v, input logic [31:0] vlast, input int n,
                              input bit toggle, output int close_cyc, output int rdy_cycles);
        int  sent;
        int  guard;
        bit  take;
        sent = 0;
        guard = 0;
        close_cyc = -1;
        rdy_cycles = 0;
        while (sent < n && guard < 400) begin
            in_valid = toggle ? ((guard % 2) == 0) : 1'b1;
            in_data  = (sent == n - 1) ? vlast : v;
            in_last  = (sent == n - 1);
            if (in_ready) rdy_cycles++;
            take = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (take) begin
                sent++;
                if (sent == n) close_cyc = cyc;
            end
            guard++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_sum(output int at);
        at = -1;
        for (int i = 0; i < 60; i++) begin
            if (sum_valid) begin
                at = cyc;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic handshake();
        sum_ready = 1'b1;
        @(posedge clk);
        #1;
        sum_ready = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        rst_n = 1'b0;
        #1;
        bad = 0;
        for (int i = 0; i < N; i++) if (vec_out[i] !== 32'h0) bad++;
        total_cnt++;
        if (bad !== 0) $display("FAIL reset_vec: %0d nonzero slots, expected 0", bad);
        else pass_cnt++;
        total_cnt++;
        if ({sum_valid, sum_invalid, in_ready} !== 3'b001)
            $display("FAIL reset_ctrl: valid/invalid/ready=%b expected 001",
                     {sum_valid, sum_invalid, in_ready});
        else pass_cnt++;
        total_cnt++;
        if (sum_data !== 32'h0) $display("FAIL reset_sum: got %h expected 0", sum_data);
        else pass_cnt++;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_full_frame();
        int cc, rdy, at;
        exp_tree = 32'h42480000;
        push_frame(32'h3F800000, 32'h3F800000, N, 1'b0, cc, rdy);
        total_cnt++;
        if (rdy !== N) $display("FAIL full_ready_cycles: got %0d expected %0d", rdy, N);
        else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL full_ready_drop: got %b expected 0", in_ready);
        else pass_cnt++;
        total_cnt++;
        if (vec_out[0] !== 32'h3F800000 || vec_out[N-1] !== 32'h3F800000)
            $display("FAIL full_vec: got %h/%h expected 3f800000", vec_out[0], vec_out[N-1]);
        else pass_cnt++;
        wait_sum(at);
        total_cnt++;
        if (at - cc !== L + 1 || at < 0 || cc < 0)
            $display("FAIL full_latency: got %0d expected %0d", at - cc, L + 1);
        else pass_cnt++;
        total_cnt++;
        if (sum_data !== 32'h42480000) $display("FAIL full_sum: got %h expected 42480000", sum_data);
        else pass_cnt++;
        handshake();
        total_cnt++;
        if ({sum_valid, in_ready} !== 2'b01)
            $display("FAIL full_release: valid/ready=%b expected 01", {sum_valid, in_ready});
        else pass_cnt++;
    endtask

    task automatic test_toggle();
        int cc, rdy, at;
        exp_tree = 32'h43160000;
        push_frame(32'h40400000, 32'h40400000, N, 1'b1, cc, rdy);
        total_cnt++;
        if (vec_out[N-1] !== 32'h40400000 || vec_out[25] !== 32'h40400000)
            $display("FAIL toggle_vec: got %h/%h expected 40400000", vec_out[25], vec_out[N-1]);
        else pass_cnt++;
        wait_sum(at);
        total_cnt++;
        if (at - cc !== L + 1 || at < 0 || cc < 0)
            $display("FAIL toggle_latency: got %0d expected %0d", at - cc, L + 1);
        else pass_cnt++;
        total_cnt++;
        if (sum_data !== 32'h43160000) $display("FAIL toggle_sum: got %h expected 43160000", sum_data);
        else pass_cnt++;
        handshake();
    endtask

    // Leaves the sum pending for test_backpressure.
    task automatic test_short_frame();
        int cc, rdy, at, bad;
        exp_tree = 32'h41000000;
        push_frame(32'h40000000, 32'h40000000, 4, 1'b0, cc, rdy);
        bad = 0;
        for (int i = 4; i < N; i++) if (vec_out[i] !== 32'h0) bad++;
        total_cnt++;
        if (vec_out[3] !== 32'h40000000 || bad !== 0)
            $display("FAIL short_vec: slot3=%h nonzero_tail=%0d expected 40000000/0",
                     vec_out[3], bad);
        else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL short_close: in_ready=%b expected 0", in_ready);
        else pass_cnt++;
        wait_sum(at);
        total_cnt++;
        if (sum_data !== 32'h41000000 || at - cc !== L + 1 || at < 0)
            $display("FAIL short_sum: got %h lat %0d expected 41000000 lat %0d",
                     sum_data, at - cc, L + 1);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int bad, zeros;
        bad = 0;
        in_valid = 1'b1;
        in_data  = 32'h12345678;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (sum_valid !== 1'b1 || sum_data !== 32'h41000000 || in_ready !== 1'b0 ||
                vec_out[0] !== 32'h40000000 || vec_out[4] !== 32'h0) bad++;
        end
        in_valid = 1'b0;
        total_cnt++;
        if (bad !== 0) $display("FAIL bp_stable: %0d unstable cycles expected 0", bad);
        else pass_cnt++;
        handshake();
        zeros = 0;
        for (int i = 0; i < N; i++) if (vec_out[i] === 32'h0) zeros++;
        total_cnt++;
        if ({sum_valid, in_ready} !== 2'b01 || zeros !== N)
            $display("FAIL bp_release: valid/ready=%b zero_slots=%0d expected 01/%0d",
                     {sum_valid, in_ready}, zeros, N);
        else pass_cnt++;
    endtask

    task automatic test_reset_in_hold();
        int cc, rdy, at, seen;
        exp_tree = 32'h42480000;
        push_frame(32'h3F800000, 32'h3F800000, N, 1'b0, cc, rdy);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({sum_valid, in_ready} !== 2'b01 || vec_out[0] !== 32'h0 || sum_data !== 32'h0)
            $display("FAIL hold_reset: valid/ready=%b slot0=%h sum=%h expected 01/0/0",
                     {sum_valid, in_ready}, vec_out[0], sum_data);
        else pass_cnt++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (sum_valid) seen++;
        end
        total_cnt++;
        if (seen !== 0) $display("FAIL hold_no_sum: sum_valid seen %0d cycles expected 0", seen);
        else pass_cnt++;
        push_frame(32'h3F800000, 32'h3F800000, N, 1'b0, cc, rdy);
        wait_sum(at);
        total_cnt++;
        if (sum_data !== 32'h42480000 || at < 0)
            $display("FAIL hold_next_sum: got %h expected 42480000", sum_data);
        else pass_cnt++;
        handshake();
    endtask

    task automatic test_nan();
        int cc, rdy, at;
        exp_tree = 32'h7FC00000;
        push_frame(32'h3F800000, 32'h7FC00000, N, 1'b0, cc, rdy);
        wait_sum(at);
`ifdef COLLECTOR_NAN_FLAG_EN
        total_cnt++;
        if (sum_invalid !== 1'b1 || at < 0)
            $display("FAIL nan_flag: got %b expected 1", sum_invalid);
        else pass_cnt++;
`else
        total_cnt++;
        if (sum_invalid !== 1'b0 || at < 0)
            $display("FAIL nan_flag_off: got %b expected 0", sum_invalid);
        else pass_cnt++;
`endif
        handshake();
        exp_tree = 32'h42480000;
        push_frame(32'h3F800000, 32'h3F800000, N, 1'b0, cc, rdy);
        wait_sum(at);
        total_cnt++;
        if (sum_invalid !== 1'b0 || sum_data !== 32'h42480000 || at < 0)
            $display("FAIL nan_clean: invalid=%b sum=%h expected 0/42480000",
                     sum_invalid, sum_data);
        else pass_cnt++;
        handshake();
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_toggle();
        test_short_frame();
        test_backpressure();
        test_reset_in_hold();
        test_nan();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
